// File: rtl/bf_pkg.sv
// Shared beamformer definitions: coefficient selects, LO codes and the
// weight-controller FSM states.
package bf_pkg;

  typedef enum logic [1:0] {
    SEL_COS1 = 2'd0,
    SEL_SIN1 = 2'd1,
    SEL_COS2 = 2'd2,
    SEL_SIN2 = 2'd3
  } coef_sel_t;

  localparam logic [1:0] LO_POS  = 2'b01;
  localparam logic [1:0] LO_ZERO = 2'b00;
  localparam logic [1:0] LO_NEG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

endpackage

// File: rtl/bf_lo_gen.sv
// Free-running two-bit LO phase counter with quadrature LO code decode,
// shared by the beamformer blocks.
module bf_lo_gen
  import bf_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] lo_phase,
  output logic [1:0] lo_i,
  output logic [1:0] lo_q
);

  always_ff @(posedge clock) begin
    if (reset) lo_phase <= 2'd0;
    else       lo_phase <= lo_phase + 2'd1;
  end

  // I leads Q by one phase step: cos and sin sampled at 0, 90, 180, 270 degrees
  always_comb begin
    lo_i = LO_ZERO;
    lo_q = LO_ZERO;
    case (lo_phase)
      2'd0: begin lo_i = LO_POS;  lo_q = LO_ZERO; end
      2'd1: begin lo_i = LO_ZERO; lo_q = LO_POS;  end
      2'd2: begin lo_i = LO_NEG;  lo_q = LO_ZERO; end
      default: begin lo_i = LO_ZERO; lo_q = LO_NEG; end
    endcase
  end

endmodule

// File: rtl/bf_weight_ctrl.sv
// Double-buffered beamformer weight store: writes land in a shadow bank and
// the whole bank is committed to the active outputs on the LO 3->0 wrap.
module bf_weight_ctrl
  import bf_pkg::*;
#(
  parameter int NCH = 8,
  parameter int WW  = 5,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CW-1:0]     wr_ch,
  input  logic [1:0]        wr_sel,
  input  logic [WW-1:0]     wr_data,
  input  logic              wr_last,
  output logic [NCH*WW-1:0] w_cos_1,
  output logic [NCH*WW-1:0] w_sin_1,
  output logic [NCH*WW-1:0] w_cos_2,
  output logic [NCH*WW-1:0] w_sin_2,
  output logic [1:0]        LO_i,
  output logic [1:0]        LO_q,
  output logic [1:0]        lo_phase,
  output logic              commit_pending,
  output logic [7:0]        commit_cnt,
  output logic              err_ch
);

  state_t        state;
  logic [WW-1:0] shadow [NCH][4];
  logic [WW-1:0] active [NCH][4];
  logic          accept;
  logic          ch_ok;
  logic          commit;

  bf_lo_gen u_lo_gen (
    .clock    (clock),
    .reset    (reset),
    .lo_phase (lo_phase),
    .lo_i     (LO_i),
    .lo_q     (LO_q)
  );

  assign accept = wr_valid && wr_ready;
  assign ch_ok  = 32'(wr_ch) < NCH;
  assign commit = (state == ST_ARMED) && (lo_phase == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      wr_ready       <= 1'b1;
      commit_pending <= 1'b0;
      commit_cnt     <= 8'd0;
      err_ch         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            if (wr_last) begin
              state          <= ST_ARMED;
              wr_ready       <= 1'b0;
              commit_pending <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_ARMED: begin
          if (lo_phase == 2'd3) begin
            state          <= ST_IDLE;
            wr_ready       <= 1'b1;
            commit_pending <= 1'b0;
            commit_cnt     <= commit_cnt + 8'd1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          wr_ready       <= 1'b1;
          commit_pending <= 1'b0;
        end
      endcase
      if (accept && !ch_ok) err_ch <= 1'b1;
    end
  end

  // Writes are never accepted while armed, so commit and shadow update cannot collide
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int s = 0; s < 4; s++) begin
          shadow[c][s] <= '0;
          active[c][s] <= '0;
        end
      end
    end else if (commit) begin
      active <= shadow;
    end else if (accept && ch_ok) begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ch == CW'(c)) shadow[c][wr_sel] <= wr_data;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign w_cos_1[c*WW +: WW] = active[c][SEL_COS1];
    assign w_sin_1[c*WW +: WW] = active[c][SEL_SIN1];
    assign w_cos_2[c*WW +: WW] = active[c][SEL_COS2];
    assign w_sin_2[c*WW +: WW] = active[c][SEL_SIN2];
  end

endmodule

// File: tb/tb_bf_weight_ctrl.sv
// Randomised bench for bf_weight_ctrl, compared every cycle against a
// transaction-level model of the shadow/active banks and LO sequence.
module tb_bf_weight_ctrl;

  localparam int NCH = 8;
  localparam int WW  = 5;
  localparam int CW  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [CW-1:0]     wr_ch;
  logic [1:0]        wr_sel;
  logic [WW-1:0]     wr_data;
  logic              wr_last;
  logic [NCH*WW-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic [1:0]        LO_i, LO_q, lo_phase;
  logic              commit_pending;
  logic [7:0]        commit_cnt;
  logic              err_ch;

  int total = 0;
  int bad   = 0;

  int           m_phase;
  int           m_cnt;
  bit           m_armed;
  bit           m_err;
  logic [WW-1:0] m_sh  [NCH][4];
  logic [WW-1:0] m_act [NCH][4];
  logic [1:0]   lo_i_tab [4];
  logic [1:0]   lo_q_tab [4];

  bf_weight_ctrl #(.NCH(NCH), .WW(WW), .CW(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_ch          (wr_ch),
    .wr_sel         (wr_sel),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .w_cos_1        (w_cos_1),
    .w_sin_1        (w_sin_1),
    .w_cos_2        (w_cos_2),
    .w_sin_2        (w_sin_2),
    .LO_i           (LO_i),
    .LO_q           (LO_q),
    .lo_phase       (lo_phase),
    .commit_pending (commit_pending),
    .commit_cnt     (commit_cnt),
    .err_ch         (err_ch)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NCH*WW-1:0] modelFlat(input int s);
    logic [NCH*WW-1:0] f;
    f = '0;
    for (int c = 0; c < NCH; c++) f[c*WW +: WW] = m_act[c][s];
    return f;
  endfunction

  task automatic modelReset();
    m_phase = 0;
    m_cnt   = 0;
    m_armed = 0;
    m_err   = 0;
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 4; s++) begin
        m_sh[c][s]  = '0;
        m_act[c][s] = '0;
      end
  endtask

  // Effect of one rising edge given the inputs presented during the cycle
  task automatic modelEdge(input bit rst, input bit v, input int ch, input int sel,
                           input logic [WW-1:0] data, input bit last);
    if (rst) begin
      modelReset();
    end else begin
      if (m_armed && m_phase == 3) begin
        for (int c = 0; c < NCH; c++)
          for (int s = 0; s < 4; s++) m_act[c][s] = m_sh[c][s];
        m_cnt   = (m_cnt + 1) % 256;
        m_armed = 0;
      end else if (!m_armed && v) begin
        if (ch < NCH) m_sh[ch][sel] = data;
        else          m_err = 1;
        if (last) m_armed = 1;
      end
      m_phase = (m_phase + 1) % 4;
    end
  endtask

  task automatic compareAll();
    checkOutput("lo_phase", 64'(lo_phase), 64'(m_phase));
    checkOutput("LO_i", 64'(LO_i), 64'(lo_i_tab[m_phase]));
    checkOutput("LO_q", 64'(LO_q), 64'(lo_q_tab[m_phase]));
    checkOutput("wr_ready", 64'(wr_ready), 64'(!m_armed));
    checkOutput("commit_pending", 64'(commit_pending), 64'(m_armed));
    checkOutput("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
    checkOutput("err_ch", 64'(err_ch), 64'(m_err));
    checkOutput("w_cos_1", 64'(w_cos_1), 64'(modelFlat(0)));
    checkOutput("w_sin_1", 64'(w_sin_1), 64'(modelFlat(1)));
    checkOutput("w_cos_2", 64'(w_cos_2), 64'(modelFlat(2)));
    checkOutput("w_sin_2", 64'(w_sin_2), 64'(modelFlat(3)));
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input int ch, input int sel,
                               input logic [WW-1:0] data, input bit last);
    @(negedge clock);
    compareAll();
    reset    = rst;
    wr_valid = v;
    wr_ch    = CW'(ch);
    wr_sel   = 2'(sel);
    wr_data  = data;
    wr_last  = last;
    modelEdge(rst, v, ch, sel, data, last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0);
  endtask

  // Idle until the next driven cycle is in phase p with the FSM accepting writes
  task automatic alignPhase(input int p);
    for (int i = 0; i < 16 && (m_phase != p || m_armed); i++) idle(1);
  endtask

  task automatic drainCommit();
    for (int i = 0; i < 8 && m_armed; i++) idle(1);
  endtask

  initial begin
    int edges;
    int idx;
    logic [7:0] cnt0;
    lo_i_tab = '{2'b01, 2'b00, 2'b10, 2'b00};
    lo_q_tab = '{2'b00, 2'b01, 2'b00, 2'b10};
    reset = 1'b1; wr_valid = 0; wr_ch = '0; wr_sel = '0; wr_data = '0; wr_last = 0;
    modelReset();

    applyStimulus(1, 0, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0);
    idle(6);

    // Single write in phase 1, committed at the next wrap
    alignPhase(1);
    applyStimulus(0, 1, 2, 0, 5'h0B, 1);
    drainCommit();
    idle(1);
    checkOutput("single_w_cos_1_ch2", 64'(w_cos_1[2*WW +: WW]), 64'h0B);
    checkOutput("single_commit_cnt", 64'(commit_cnt), 64'd1);

    // Full 32-entry batch with a stuttering valid
    idx = 0;
    for (int k = 0; k < 400 && idx < 32; k++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      applyStimulus(0, v, idx / 4, idx % 4, WW'($urandom), idx == 31);
      if (v) idx++;
    end
    drainCommit();
    idle(2);

    // wr_last accepted on the edge leaving phase 3 waits a full LO period
    alignPhase(3);
    cnt0 = 8'(m_cnt);
    applyStimulus(0, 1, 5, 3, WW'($urandom), 1);
    edges = 99;
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      if (commit_cnt != cnt0 && edges == 99) edges = i - 1;
    end
    checkOutput("late_last_latency", 64'(edges), 64'd4);

    // Out-of-range channel: flagged, ignored, batch still commits
    applyStimulus(0, 1, 8, 1, 5'h1F, 0);
    applyStimulus(0, 1, 9, 2, 5'h15, 1);
    drainCommit();
    idle(3);
    checkOutput("err_sticky", 64'(err_ch), 64'd1);

    // Reset while armed discards the batch
    alignPhase(0);
    applyStimulus(0, 1, 1, 0, 5'h07, 1);
    applyStimulus(1, 0, 0, 0, '0, 0);
    idle(8);
    checkOutput("rst_armed_cnt", 64'(commit_cnt), 64'd0);
    checkOutput("rst_armed_w", 64'(w_cos_1), 64'd0);

    // 256 commits wrap the counter
    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 1, $urandom_range(0, 7), $urandom_range(0, 3), WW'($urandom), 1);
      drainCommit();
    end
    idle(1);
    checkOutput("cnt_wrap", 64'(commit_cnt), 64'd0);

    // Fully random traffic, including bad channels and occasional resets
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9), $urandom_range(0, 3), WW'($urandom),
                    $urandom_range(0, 3) == 0);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_weight_ctrl.md
BF_WEIGHT_CTRL -- requirements
Module: bf_weight_ctrl

Interface
REQ-001 The block SHALL provide parameter NCH, default 8, meaning the number of beam channels.
REQ-002 The block SHALL provide parameter WW, default 5, meaning the signed weight width in bits.
REQ-003 The block SHALL provide parameter CW, default $clog2(NCH), meaning the channel index width.
REQ-004 clock  in  1  system clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_valid  in  1  weight write request.
REQ-007 wr_ready  out  1  write accepted this cycle when wr_valid=1 and wr_ready=1.
REQ-008 wr_ch  in  CW  target channel.
REQ-009 wr_sel  in  2  coefficient select: 0 cos_1, 1 sin_1, 2 cos_2, 3 sin_2.
REQ-010 wr_data  in  WW  weight value.
REQ-011 wr_last  in  1  marks the final write of a batch.
REQ-012 w_cos_1, w_sin_1, w_cos_2, w_sin_2  out  NCH x WW each  active weights per channel.
REQ-013 LO_i, LO_q  out  2 each  local-oscillator codes: 01 = +1, 00 = 0, 10 = -1.
REQ-014 lo_phase  out  2  current LO phase counter.
REQ-015 commit_pending  out  1  high while a batch is waiting for commit.
REQ-016 commit_cnt  out  8  number of completed commits.
REQ-017 err_ch  out  1  sticky flag for a write to a channel >= NCH.

Function
REQ-018 lo_phase SHALL increment by 1 every cycle and wrap from 3 to 0.
REQ-019 LO_i SHALL be 01, 00, 10, 00 for lo_phase 0, 1, 2, 3; LO_q SHALL be 00, 01, 00, 10 for the same phases (combinational from lo_phase).
REQ-020 The FSM SHALL have three states: IDLE, LOAD and ARMED.
REQ-021 IDLE transitions: accepted write with wr_last=0 goes to LOAD; accepted write with wr_last=1 goes to ARMED.
REQ-022 LOAD transitions: accepted write with wr_last=1 goes to ARMED; otherwise the FSM stays in LOAD.
REQ-023 ARMED transitions: when lo_phase==3, the FSM goes to IDLE on the same edge that performs the commit.
REQ-024 wr_ready SHALL be 1 in IDLE and LOAD and 0 in ARMED; commit_pending SHALL be 1 only in ARMED.
REQ-025 Each accepted write SHALL update shadow[wr_ch][wr_sel] on that edge; the shadow bank SHALL retain unwritten entries across commits, so partial updates are legal.
REQ-026 Commit SHALL copy the entire shadow bank into the active bank on the 3->0 lo_phase edge, so new weights first appear with lo_phase==0.
REQ-027 A batch whose wr_last is accepted on the edge leaving lo_phase==3 SHALL commit on the next 3->0 edge, 4 cycles later; it SHALL never commit in the same cycle.
REQ-028 commit_cnt SHALL increment by 1 per commit and wrap from 255 to 0.
REQ-029 A write with wr_ch >= NCH SHALL complete the handshake, leave the shadow bank unchanged, still honour wr_last, and set err_ch until reset.
REQ-030 Active outputs SHALL be registered and change only on a commit edge or on reset.

Reset
REQ-031 On reset the block SHALL set lo_phase=0 (LO_i=01, LO_q=00), state=IDLE, wr_ready=1, commit_pending=0, commit_cnt=0, err_ch=0, and all shadow and active weights to 0.
REQ-032 Reset asserted mid-batch or in ARMED SHALL discard the batch with no commit.

Structure
REQ-033 The shared package bf_pkg SHALL hold the wr_sel coefficient enum, the LO code constants (LO_POS=01, LO_ZERO=00, LO_NEG=10) and the FSM state typedef.
REQ-034 The phase counter and LO decode SHALL be a sub-module bf_lo_gen so the other beamformer blocks can reuse it.

Verification
REQ-035 Reset release -> lo_phase sequence 0,1,2,3,0; LO_i 01,00,10,00; LO_q 00,01,00,10; all weights 0.
REQ-036 Write ch2 cos_1=5'h0B (last=1) in lo_phase 1 -> commit_pending for 2 cycles; w_cos_1[2]=0B first seen with lo_phase 0; commit_cnt=1; wr_ready low while armed.
REQ-037 32-write batch loading every channel and coefficient, wr_last on the final write, with wr_valid toggling randomly -> no active change until commit, then all 32 values appear on one edge.
REQ-038 wr_last accepted leaving lo_phase 3 -> commit occurs 4 cycles later, not 0.
REQ-039 Write to wr_ch=8 with NCH=8 (CW=4 build) -> err_ch=1 and sticky; no weight change; batch still commits.
REQ-040 Reset pulsed in ARMED and 256 back-to-back commits -> no commit and weights 0 after the reset; commit_cnt wraps to 0 after commit 256.
